alu4_arb_ctrl: RTL

Two-port arbiter and sequencer that shares the single 4-bit combinational ALU of the tt_um_Cameron_ALU design between two requesters. It accepts operand/opcode bundles over valid/ready handshakes, grants one requester at a time, and drives registered operands into the ALU. It captures the ALU result and flags one cycle later and returns them with the requester ID over a valid/ready response channel. It sits between the pin-level input decode and the shared ALU instance.

---
 rtl/alu4_arb_ctrl_if.sv | 58 +++++
 rtl/alu4_arb_ctrl.sv | 100 ++++++++++
 2 files changed

// File: rtl/alu4_arb_ctrl_if.sv
// Request, ALU and response bundle for alu4_arb_ctrl.
// The slave modport is the controller's view; the master modport drives it.
interface alu4_arb_ctrl_if #(
    parameter int DW  = 4,
    parameter int OPW = 3
);
    logic           req0_valid;
    logic           req0_ready;
    logic [DW-1:0]  req0_a;
    logic [DW-1:0]  req0_b;
    logic [OPW-1:0] req0_op;

    logic           req1_valid;
    logic           req1_ready;
    logic [DW-1:0]  req1_a;
    logic [DW-1:0]  req1_b;
    logic [OPW-1:0] req1_op;

    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [OPW-1:0] alu_op;
    logic [DW-1:0]  alu_y;
    logic           alu_c;
    logic           alu_z;

    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [DW-1:0]  rsp_y;
    logic           rsp_c;
    logic           rsp_z;

    logic           busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_y, alu_c, alu_z,
        output rsp_valid, rsp_id, rsp_y, rsp_c, rsp_z,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_y, alu_c, alu_z,
        input  rsp_valid, rsp_id, rsp_y, rsp_c, rsp_z,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/alu4_arb_ctrl.sv
// Two-requester arbiter/sequencer in front of one shared 4-bit ALU.
// Define ALU_ARB_RR_EN for round-robin; default is fixed priority to requester 0.
module alu4_arb_ctrl #(
    parameter int DW  = 4,
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst,
    alu4_arb_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } state_t;

    state_t         state;
    logic           last_grant;
    logic           any_valid;
    logic           pick1;
    logic           idle;
    logic [DW-1:0]  sel_a;
    logic [DW-1:0]  sel_b;
    logic [OPW-1:0] sel_op;

    assign idle      = (state == IDLE);
    assign any_valid = bus.req0_valid | bus.req1_valid;

`ifdef ALU_ARB_RR_EN
    // On contention, favour whoever did not win last time.
    assign pick1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign pick1 = bus.req1_valid & ~bus.req0_valid;
`endif

    assign bus.req0_ready = idle & bus.req0_valid & ~pick1;
    assign bus.req1_ready = idle & pick1;
    assign bus.busy       = ~idle;

    always_comb begin
        sel_a  = bus.req0_a;
        sel_b  = bus.req0_b;
        sel_op = bus.req0_op;
        unique case (1'b1)
            pick1: begin
                sel_a  = bus.req1_a;
                sel_b  = bus.req1_b;
                sel_op = bus.req1_op;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_op    <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_y     <= '0;
            bus.rsp_c     <= 1'b0;
            bus.rsp_z     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_valid) begin
                        bus.alu_a  <= sel_a;
                        bus.alu_b  <= sel_b;
                        bus.alu_op <= sel_op;
                        bus.rsp_id <= pick1;
                        last_grant <= pick1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU output has had a full cycle to settle.
                    bus.rsp_y     <= bus.alu_y;
                    bus.rsp_c     <= bus.alu_c;
                    bus.rsp_z     <= bus.alu_z;
                    bus.rsp_valid <= 1'b1;
                    state         <= HOLD;
                end
                HOLD: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
